// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers, one radix-2 step per cycle.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built only when MDU_MADD_EN is defined.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_DIVU  = 4'b0101;
  localparam logic [3:0] OP_MFHI  = 4'b0110;
  localparam logic [3:0] OP_MFLO  = 4'b0111;
  localparam logic [3:0] OP_MTHI  = 4'b1000;
  localparam logic [3:0] OP_MTLO  = 4'b1001;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b1010;
  localparam logic [3:0] OP_MADDU = 4'b1011;
  localparam logic [3:0] OP_MSUB  = 4'b1100;
  localparam logic [3:0] OP_MSUBU = 4'b1101;
`endif

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [3:0]         op_r;
  logic               neg_a, neg_b;

  logic               start, accept, is_div_in, sgn_in, is_div_r;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum, trial, diff;
  logic [2*WIDTH-1:0] step, res_mul, hilo_nxt;
  logic [WIDTH-1:0]   quo, rem;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  always_comb begin
    start = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: start = 1'b1;
`endif
      default: start = 1'b0;
    endcase
  end

  // Signed variants all have op[0] == 0 among the start ops
  assign sgn_in    = ~op[0];
  assign is_div_in = (op == OP_DIV) || (op == OP_DIVU);
  assign abs_a     = magnitude(d1, sgn_in);
  assign abs_b     = magnitude(d2, sgn_in);
  assign accept    = (state == S_IDLE) && start && !flush;
  assign busy      = (state != S_IDLE) || accept;
  assign is_div_r  = (op_r == OP_DIV) || (op_r == OP_DIVU);

  // prod holds {partial, multiplier} for multiply and {remainder, dividend} for divide
  always_comb begin
    add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
    trial   = prod[2*WIDTH-1:WIDTH-1];
    diff    = trial - {1'b0, mag_b};
    if (is_div_r)
      step = diff[WIDTH] ? {prod[2*WIDTH-2:0], 1'b0}
                         : {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    else
      step = {add_sum, prod[WIDTH-1:1]};
  end

  always_comb begin
    res_mul = (neg_a ^ neg_b) ? -prod : prod;
    quo     = (neg_a ^ neg_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem     = neg_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    hilo_nxt = {hi, lo};
    case (op_r)
      OP_MULT, OP_MULTU: hilo_nxt = res_mul;
      OP_DIV, OP_DIVU:   if (mag_b != '0) hilo_nxt = {rem, quo};
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: hilo_nxt = {hi, lo} + res_mul;
      OP_MSUB, OP_MSUBU: hilo_nxt = {hi, lo} - res_mul;
`endif
      default: hilo_nxt = {hi, lo};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      prod     <= '0;
      op_r     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_CALC;
            cnt      <= CW'(WIDTH - 1);
            op_r     <= op;
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            neg_a    <= sgn_in & d1[WIDTH-1];
            neg_b    <= sgn_in & d2[WIDTH-1];
            prod     <= {{WIDTH{1'b0}}, is_div_in ? abs_a : abs_b};
            div_zero <= 1'b0;
          end else if (op == OP_MTHI) begin
            hi <= d1;
          end else if (op == OP_MTLO) begin
            lo <= d1;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            prod <= step;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          if (!flush) begin
            {hi, lo} <= hilo_nxt;
            if (is_div_r && mag_b == '0) div_zero <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dout = (op == OP_MFHI) ? hi :
                (op == OP_MFLO) ? lo : '0;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32): vector table plus flush, reset and HI/LO move sequences.
module tb_mdu_iter;
  localparam logic [3:0] NONE = 4'b0000, MULT = 4'b0010, MULTU = 4'b0011,
                         DIV = 4'b0100, DIVU = 4'b0101, MFHI = 4'b0110, MFLO = 4'b0111,
                         MTHI = 4'b1000, MTLO = 4'b1001, MADDU = 4'b1011, MSUB = 4'b1100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  op = NONE;
  logic [31:0] d1 = '0, d2 = '0;
  logic        flush = 1'b0;
  logic [31:0] dout;
  logic        busy, div_zero;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op(op), .d1(d1), .d2(d2), .flush(flush),
    .dout(dout), .busy(busy), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    op = MFHI; #1 h = dout;
    op = MFLO; #1 l = dout;
    op = NONE; #1;
  endtask

  task automatic move(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk); op = o; d1 = v;
    @(negedge clk); op = NONE;
  endtask

  // cyc counts busy cycles from the accept cycle, bounded
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk); op = o; d1 = a; d2 = b; #1;
    cyc = busy ? 1 : 0;
    @(negedge clk); op = NONE;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  vec_t vecs[11];
  logic [31:0] h, l, h0, l0;
  int cyc;

  initial begin
    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    vecs[5]  = '{DIVU,  32'd9,        32'd0,        32'd1,        32'd3,        1'b1};
    vecs[6]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[9]  = '{MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};
    vecs[10] = '{DIVU,  32'd5,        32'd7,        32'd5,        32'd0,        1'b0};

    // reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_dz", div_zero, 1'b0);
    chk("rst_dout", dout, 0);
    read_hilo(h, l);
    chk("rst_hi", h, 0);
    chk("rst_lo", l, 0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      read_hilo(h, l);
      chk($sformatf("v%0d_busy_cycles", i), cyc, 34);
      chk($sformatf("v%0d_hi", i), h, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), l, vecs[i].lo);
      chk($sformatf("v%0d_dz", i), div_zero, vecs[i].dz);
    end

    // MTLO then divide by zero keeps HI/LO, sets div_zero; next accept clears it
    move(MTHI, 32'h55);
    move(MTLO, 32'h1234);
    read_hilo(h, l);
    chk("mthi", h, 32'h55);
    chk("mtlo", l, 32'h1234);
    run_op(DIVU, 32'd100, 32'd0, cyc);
    read_hilo(h, l);
    chk("dz_cycles", cyc, 34);
    chk("dz_lo", l, 32'h1234);
    chk("dz_hi", h, 32'h55);
    chk("dz_flag", div_zero, 1'b1);
    @(negedge clk); op = MULTU; d1 = 32'd3; d2 = 32'd4;
    @(negedge clk); op = NONE;
    chk("dz_clear", div_zero, 1'b0);
    // MTLO while busy must be ignored
    op = MTLO; d1 = 32'hDEAD;
    @(negedge clk); op = NONE;
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    read_hilo(h, l);
    chk("busy_mt_hi", h, 0);
    chk("busy_mt_lo", l, 32'd12);

    // flush on the 10th CALC cycle
    read_hilo(h0, l0);
    @(negedge clk); op = MULTU; d1 = 32'hFFFFFFFF; d2 = 32'd2;
    repeat (10) begin @(negedge clk); op = NONE; end
    chk("flush_pre_busy", busy, 1'b1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    read_hilo(h, l);
    chk("flush_hi", h, h0);
    chk("flush_lo", l, l0);
    // flush in IDLE suppresses acceptance
    @(negedge clk); op = MULT; d1 = 32'd2; d2 = 32'd2; flush = 1'b1; #1;
    chk("flush_idle_busy", busy, 1'b0);
    @(negedge clk); op = NONE; flush = 1'b0;
    chk("flush_idle_next", busy, 1'b0);
    read_hilo(h, l);
    chk("flush_idle_lo", l, l0);

    // accumulate ops
    move(MTHI, 32'h0);
    move(MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op(MADDU, 32'd1, 32'd1, cyc);
    read_hilo(h, l);
    chk("maddu_cycles", cyc, 34);
    chk("maddu_hi", h, 32'd1);
    chk("maddu_lo", l, 32'd0);
    run_op(MSUB, 32'd1, 32'd1, cyc);
    read_hilo(h, l);
    chk("msub_hi", h, 32'd0);
    chk("msub_lo", l, 32'hFFFFFFFF);
`else
    run_op(MADDU, 32'd1, 32'd1, cyc);
    read_hilo(h, l);
    chk("maddu_off_busy", cyc, 0);
    chk("maddu_off_hi", h, 32'd0);
    chk("maddu_off_lo", l, 32'hFFFFFFFF);
`endif

    // async reset mid-DIV with div_zero and HI/LO nonzero
    run_op(DIVU, 32'd1, 32'd0, cyc);
    chk("pre_rst_dz", div_zero, 1'b1);
    @(negedge clk); op = DIV; d1 = 32'd50; d2 = 32'd7;
    repeat (5) begin @(negedge clk); op = NONE; end
    chk("pre_rst_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_dz", div_zero, 1'b0);
    op = MFHI; #0.5;
    chk("arst_hi", dout, 0);
    op = MFLO; #0.5;
    chk("arst_lo", dout, 0);
    op = NONE;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; legal values are even integers 8..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 op  input  4  operation code, sampled every cycle.
REQ-005 d1  input  WIDTH  operand A: dividend, multiplicand, or MTHI/MTLO data.
REQ-006 d2  input  WIDTH  operand B: divisor or multiplier.
REQ-007 flush  input  1  abort the in-flight operation.
REQ-008 dout  output  WIDTH  HI on MFHI, LO on MFLO, else 0; combinational.
REQ-009 busy  output  1  unit occupied or accepting a start op this cycle.
REQ-010 div_zero  output  1  sticky flag: the last completed divide had d2 == 0.

Function
REQ-011 Op codes: 0000 none; 0010 MULT; 0011 MULTU; 0100 DIV; 0101 DIVU; 0110 MFHI; 0111 MFLO; 1000 MTHI; 1001 MTLO; 1010 MADD; 1011 MADDU; 1100 MSUB; 1101 MSUBU; all others no-op.
REQ-012 Start ops: MULT, MULTU, DIV, DIVU, plus MADD..MSUBU when enabled.
REQ-013 FSM states: IDLE, CALC, FIN.
REQ-014 Accept: at a clk edge in IDLE with a start op and flush=0, latch operand magnitudes and sign info, load counter=WIDTH-1, go to CALC, clear div_zero.
REQ-015 CALC runs one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle; the counter decrements; at counter 0 go to FIN (WIDTH cycles in CALC).
REQ-016 FIN applies the sign correction, writes HI/LO on the next edge, then returns to IDLE; HI/LO update WIDTH+1 edges after the accept edge.
REQ-017 busy = (state != IDLE) | (state == IDLE & start op & ~flush).
REQ-018 MULT/MULTU: {HI,LO} = full 2*WIDTH-bit signed/unsigned product.
REQ-019 DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend; most-negative / -1 gives LO = most-negative, HI = 0.
REQ-020 DIVU: unsigned quotient to LO, remainder to HI.
REQ-021 d2 == 0 on DIV/DIVU: full latency, HI/LO unchanged at FIN, div_zero set to 1.
REQ-022 MADD/MADDU: {HI,LO} += product; MSUB/MSUBU: {HI,LO} -= product; modulo 2^(2*WIDTH), using the HI/LO values present at the commit edge.
REQ-023 MTHI/MTLO write d1 to HI/LO at the edge only in IDLE; ignored otherwise.
REQ-024 Start ops, MTHI and MTLO issued while not IDLE are ignored; the caller stalls on busy.
REQ-025 MFHI/MFLO are legal in any state and return the committed HI/LO, never partial results.
REQ-026 flush=1 at an edge in CALC or FIN returns to IDLE, leaves HI/LO and div_zero unchanged, and suppresses acceptance of a start op in the same cycle.

Reset
REQ-027 reset=0 asynchronously forces IDLE, HI=LO=0, counter=0, div_zero=0, and clears all datapath registers, including mid-operation.
REQ-028 After reset: busy = 0 unless a start op is presented; dout = 0 unless op is MFHI/MFLO.

Configuration
REQ-029 Macro MDU_MADD_EN: when defined, MADD/MADDU/MSUB/MSUBU are start ops per REQ-022; when undefined, codes 1010..1101 are no-ops, busy is not asserted, and the accumulate adder is not built.

Verification
REQ-030 WIDTH=32, MULT d1=0xFFFFFFFD, d2=5 -> busy high for 34 cycles from the accept cycle; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-031 DIV d1=0xFFFFFFF9 (-7), d2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU d1=7, d2=2 -> LO=3, HI=1.
REQ-032 MTLO 0x1234, then DIVU d2=0 -> after completion LO=0x1234, div_zero=1; the next MULTU accept clears div_zero to 0.
REQ-033 MULTU 0xFFFFFFFF*2 with flush=1 on the 10th CALC cycle -> IDLE on that edge, busy low the next cycle, HI/LO unchanged.
REQ-034 MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, MADDU d1=1, d2=1 -> HI=1, LO=0; MDU_MADD_EN undefined: same stimulus -> busy stays 0, HI/LO unchanged.
REQ-035 reset driven low asynchronously mid-DIV -> busy, HI, LO and div_zero read 0 before the next clk edge.
